// File: rtl/tetris_pkg.sv
// Shared types for the Tetris command scheduler: command codes, run states,
// USB HID keycodes and the level-dependent gravity period helper.
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_NONE      = 3'd0,
        CMD_LEFT      = 3'd1,
        CMD_RIGHT     = 3'd2,
        CMD_ROTATE    = 3'd3,
        CMD_SOFT_DROP = 3'd4,
        CMD_HARD_DROP = 3'd5,
        CMD_GRAVITY   = 3'd6,
        CMD_RESTART   = 3'd7
    } cmd_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    localparam logic [7:0] KEY_LEFT   = 8'h04;
    localparam logic [7:0] KEY_RIGHT  = 8'h07;
    localparam logic [7:0] KEY_ROTATE = 8'h1A;
    localparam logic [7:0] KEY_SOFT   = 8'h16;
    localparam logic [7:0] KEY_HARD   = 8'h2C;
    localparam logic [7:0] KEY_PAUSE  = 8'h13;
    localparam logic [7:0] KEY_ENTER  = 8'h28;

    // Saturating period: once level*step reaches base the subtraction would wrap.
    function automatic logic [7:0] gravPeriod(input logic [3:0] lvl,
                                              input logic [7:0] base,
                                              input logic [7:0] step,
                                              input logic [7:0] minPeriod);
        logic [7:0] prod;
        logic [7:0] diff;
        prod = {4'd0, lvl} * step;
        diff = base - prod;
        if (prod >= base || diff < minPeriod)
            return minPeriod;
        return diff;
    endfunction

endpackage

// File: rtl/tetris_cmd_sched_if.sv
// Valid/ready command channel from the scheduler to the block/grid engine.
interface tetris_cmd_sched_if;
    import tetris_pkg::*;

    cmd_t cmd;
    logic cmd_valid;
    logic cmd_ready;

    modport master (output cmd, output cmd_valid, input cmd_ready);
    modport slave  (input cmd, input cmd_valid, output cmd_ready);

endinterface

// File: rtl/tetris_cmd_sched_key_repeat.sv
// Per-key repeat generator: fires on a press, then after FIRST_DELAY held
// frames, then every REPEAT_PERIOD held frames.
module key_repeat #(
    parameter int FIRST_DELAY   = 10,
    parameter int REPEAT_PERIOD = 3
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_tick,
    input  logic i_press,
    input  logic i_hold,
    input  logic i_enable,
    output logic o_req
);

    localparam logic [7:0] L_FIRST = 8'(FIRST_DELAY);
    localparam logic [7:0] L_WRAP  = 8'(FIRST_DELAY + REPEAT_PERIOD);

    logic [7:0] r_holdCnt;
    logic [7:0] w_nextCnt;
    logic       w_fire;

    assign w_nextCnt = r_holdCnt + 8'd1;
    assign w_fire    = i_hold && (w_nextCnt == L_FIRST || w_nextCnt == L_WRAP);
    assign o_req     = i_tick && i_enable && (i_press || w_fire);

    // The count folds back to FIRST_DELAY at each repeat so it never overflows.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_holdCnt <= 8'd0;
        end else if (i_tick && i_enable) begin
            if (i_hold)
                r_holdCnt <= (w_nextCnt == L_WRAP) ? L_FIRST : w_nextCnt;
            else
                r_holdCnt <= 8'd0;
        end
    end

endmodule

// File: rtl/tetris_cmd_sched.sv
// Frame-rate command scheduler: keycode sampling, gravity, run/pause/over FSM
// and priority arbitration onto one command channel. Macro: TETRIS_DAS_EN.
module tetris_cmd_sched
    import tetris_pkg::*;
#(
    parameter int DAS_FRAMES  = 10,
    parameter int ARR_FRAMES  = 3,
    parameter int SOFT_FRAMES = 2,
    parameter int GRAV_BASE   = 48,
    parameter int GRAV_STEP   = 4,
    parameter int GRAV_MIN    = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      vsync,
    input  logic [7:0]                keycode,
    input  logic [3:0]                level,
    input  logic                      game_over,
    tetris_cmd_sched_if.master        bus,
    output logic                      paused,
    output logic                      running
);

    logic       r_vsyncQ;
    logic [7:0] r_kcPrev;
    logic [7:0] r_gravCnt;
    logic [7:1] r_pend;
    state_t     r_state;
    state_t     w_stateNext;

    logic       w_tick;
    logic       w_runEn;
    logic       w_clearFlags;
    logic       w_accept;
    logic       w_gravInc;
    logic       w_gravFire;
    logic       w_dropAccepted;
    logic [7:0] w_period;
    logic [7:1] w_set;
    logic [7:1] w_acceptMask;
    logic [7:1] w_pendNext;
    cmd_t       w_winner;

    logic w_pressLeft, w_pressRight, w_pressRotate, w_pressSoft;
    logic w_pressHard, w_pressPause, w_pressEnter, w_holdSoft;
    logic w_reqLeft, w_reqRight, w_reqSoft;

    assign w_tick = vsync && !r_vsyncQ;

    assign w_pressLeft   = (keycode == KEY_LEFT)   && (r_kcPrev != KEY_LEFT);
    assign w_pressRight  = (keycode == KEY_RIGHT)  && (r_kcPrev != KEY_RIGHT);
    assign w_pressRotate = (keycode == KEY_ROTATE) && (r_kcPrev != KEY_ROTATE);
    assign w_pressSoft   = (keycode == KEY_SOFT)   && (r_kcPrev != KEY_SOFT);
    assign w_pressHard   = (keycode == KEY_HARD)   && (r_kcPrev != KEY_HARD);
    assign w_pressPause  = (keycode == KEY_PAUSE)  && (r_kcPrev != KEY_PAUSE);
    assign w_pressEnter  = (keycode == KEY_ENTER)  && (r_kcPrev != KEY_ENTER);
    assign w_holdSoft    = (keycode == KEY_SOFT)   && (r_kcPrev == KEY_SOFT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vsyncQ <= 1'b0;
            r_kcPrev <= 8'd0;
            r_state  <= ST_RUN;
        end else begin
            r_vsyncQ <= vsync;
            if (w_tick)
                r_kcPrev <= keycode;
            r_state <= w_stateNext;
        end
    end

    // Game over outranks a pause toggle arriving on the same frame.
    always_comb begin
        w_stateNext = r_state;
        if (w_tick) begin
            case (r_state)
                ST_RUN: begin
                    if (game_over)         w_stateNext = ST_OVER;
                    else if (w_pressPause) w_stateNext = ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (game_over)         w_stateNext = ST_OVER;
                    else if (w_pressPause) w_stateNext = ST_RUN;
                end
                ST_OVER: begin
                    if (w_pressEnter)      w_stateNext = ST_RUN;
                end
                default: w_stateNext = ST_RUN;
            endcase
        end
    end

    // Requests and counters only advance on frames that both start and stay in RUN.
    assign w_runEn      = (r_state == ST_RUN) && (w_stateNext == ST_RUN);
    assign w_clearFlags = (w_stateNext != r_state) && (w_stateNext != ST_RUN);

`ifdef TETRIS_DAS_EN
    logic w_holdLeft, w_holdRight;
    assign w_holdLeft  = (keycode == KEY_LEFT)  && (r_kcPrev == KEY_LEFT);
    assign w_holdRight = (keycode == KEY_RIGHT) && (r_kcPrev == KEY_RIGHT);

    key_repeat #(.FIRST_DELAY(DAS_FRAMES), .REPEAT_PERIOD(ARR_FRAMES)) u_repLeft (
        .Clk(Clk), .Reset(Reset), .i_tick(w_tick), .i_press(w_pressLeft),
        .i_hold(w_holdLeft), .i_enable(w_runEn), .o_req(w_reqLeft));

    key_repeat #(.FIRST_DELAY(DAS_FRAMES), .REPEAT_PERIOD(ARR_FRAMES)) u_repRight (
        .Clk(Clk), .Reset(Reset), .i_tick(w_tick), .i_press(w_pressRight),
        .i_hold(w_holdRight), .i_enable(w_runEn), .o_req(w_reqRight));
`else
    assign w_reqLeft  = w_tick && w_runEn && w_pressLeft;
    assign w_reqRight = w_tick && w_runEn && w_pressRight;
`endif

    key_repeat #(.FIRST_DELAY(SOFT_FRAMES), .REPEAT_PERIOD(SOFT_FRAMES)) u_repSoft (
        .Clk(Clk), .Reset(Reset), .i_tick(w_tick), .i_press(w_pressSoft),
        .i_hold(w_holdSoft), .i_enable(w_runEn), .o_req(w_reqSoft));

    assign w_period   = gravPeriod(level, 8'(GRAV_BASE), 8'(GRAV_STEP), 8'(GRAV_MIN));
    assign w_gravInc  = w_tick && w_runEn;
    assign w_gravFire = w_gravInc && (({1'b0, r_gravCnt} + 9'd1) >= {1'b0, w_period});
    assign w_accept   = bus.cmd_valid && bus.cmd_ready;
    assign w_dropAccepted = w_accept &&
                            (bus.cmd == CMD_SOFT_DROP || bus.cmd == CMD_HARD_DROP);

    always_ff @(posedge Clk) begin
        if (Reset)
            r_gravCnt <= 8'd0;
        else if (w_dropAccepted || w_gravFire)
            r_gravCnt <= 8'd0;
        else if (w_gravInc)
            r_gravCnt <= r_gravCnt + 8'd1;
    end

    // New requests are OR-ed in after acceptance clears, so a same-cycle set survives.
    always_comb begin
        w_set = '0;
        w_set[CMD_LEFT]      = w_reqLeft;
        w_set[CMD_RIGHT]     = w_reqRight;
        w_set[CMD_ROTATE]    = w_tick && w_runEn && w_pressRotate;
        w_set[CMD_SOFT_DROP] = w_reqSoft;
        w_set[CMD_HARD_DROP] = w_tick && w_runEn && w_pressHard;
        w_set[CMD_GRAVITY]   = w_gravFire;
        w_set[CMD_RESTART]   = w_tick && (r_state == ST_OVER) && w_pressEnter;

        w_acceptMask = '0;
        for (int i = 1; i < 8; i++)
            w_acceptMask[i] = w_accept && (bus.cmd == cmd_t'(i));

        w_pendNext = (r_pend & ~w_acceptMask) | w_set;
        if (w_clearFlags)
            w_pendNext = w_pendNext & 7'b100_0000;
    end

    always_comb begin
        w_winner = CMD_NONE;
        if      (w_pendNext[CMD_RESTART])   w_winner = CMD_RESTART;
        else if (w_pendNext[CMD_HARD_DROP]) w_winner = CMD_HARD_DROP;
        else if (w_pendNext[CMD_ROTATE])    w_winner = CMD_ROTATE;
        else if (w_pendNext[CMD_LEFT])      w_winner = CMD_LEFT;
        else if (w_pendNext[CMD_RIGHT])     w_winner = CMD_RIGHT;
        else if (w_pendNext[CMD_SOFT_DROP]) w_winner = CMD_SOFT_DROP;
        else if (w_pendNext[CMD_GRAVITY])   w_winner = CMD_GRAVITY;
    end

    // Arbitrating on the next-state flags lets a tick's request be offered one cycle later.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pend        <= '0;
            bus.cmd_valid <= 1'b0;
            bus.cmd       <= CMD_NONE;
        end else begin
            r_pend <= w_pendNext;
            if (w_accept) begin
                bus.cmd_valid <= 1'b0;
            end else if (!bus.cmd_valid && w_winner != CMD_NONE) begin
                bus.cmd_valid <= 1'b1;
                bus.cmd       <= w_winner;
            end
        end
    end

    assign paused  = (r_state == ST_PAUSED);
    assign running = (r_state == ST_RUN);

endmodule

// File: tb/tb_tetris_cmd_sched.sv
// Scoreboard bench for tetris_cmd_sched: stimulus pushes expected commands,
// a monitor pops and compares on every accepted handshake.
module tb_tetris_cmd_sched;
   import tetris_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       vsync = 1'b0;
   logic [7:0] keycode = 8'd0;
   logic [3:0] level = 4'd0;
   logic       game_over = 1'b0;
   logic       paused;
   logic       running;

   tetris_cmd_sched_if bus();

   cmd_t expQ[$];
   int   testsRun = 0;
   int   failCount = 0;

   tetris_cmd_sched dut (
      .Clk(Clk),
      .Reset(Reset),
      .vsync(vsync),
      .keycode(keycode),
      .level(level),
      .game_over(game_over),
      .bus(bus),
      .paused(paused),
      .running(running)
   );

   // 100 MHz stand-in for the pixel clock
   always #5 Clk = ~Clk;

   // Hard stop so a stuck DUT still produces a verdict
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Monitor: every accepted command must be the next one the scoreboard expects
   always @(negedge Clk) begin
      if (!Reset && bus.cmd_valid && bus.cmd_ready) begin
         testsRun++;
         if (expQ.size() == 0) begin
            failCount++;
            $display("[TB] FAIL unexpected_cmd: got %0d, expected no command", bus.cmd);
         end else begin
            cmd_t expCmd;
            expCmd = expQ.pop_front();
            if (bus.cmd !== expCmd) begin
               failCount++;
               $display("[TB] FAIL cmd_order: got %0d, expected %0d", bus.cmd, expCmd);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #2;
      end
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // One frame tick: returns just after the clock edge that sampled the tick
   task automatic applyStimulus(input logic [7:0] kc);
      keycode = kc;
      vsync   = 1'b1;
      step(1);
      vsync   = 1'b0;
   endtask

   task automatic frame(input logic [7:0] kc, input int idleCycles);
      applyStimulus(kc);
      step(idleCycles);
   endtask

   task automatic doReset();
      Reset         = 1'b1;
      vsync         = 1'b0;
      keycode       = 8'd0;
      game_over     = 1'b0;
      bus.cmd_ready = 1'b0;
      step(2);
      Reset = 1'b0;
      expQ.delete();
   endtask

   // Raise ready for exactly one offer, with a bounded wait for it to appear
   task automatic acceptOne(input string name);
      int waited = 0;
      while (!bus.cmd_valid && waited < 20) begin
         step(1);
         waited++;
      end
      if (!bus.cmd_valid) begin
         testsRun++;
         failCount++;
         $display("[TB] FAIL %s: got no offer in 20 cycles, expected cmd_valid", name);
      end else begin
         bus.cmd_ready = 1'b1;
         step(1);
         bus.cmd_ready = 1'b0;
      end
   endtask

   task automatic checkDrained(input string name);
      checkOutput(name, 8'(expQ.size()), 8'd0);
   endtask

   initial begin
      // Reset values
      doReset();
      checkOutput("reset_valid",   bus.cmd_valid, 8'd0);
      checkOutput("reset_cmd",     bus.cmd, CMD_NONE);
      checkOutput("reset_paused",  paused, 8'd0);
      checkOutput("reset_running", running, 8'd1);

      // Level 0 gravity: one command right after the 48th tick
      bus.cmd_ready = 1'b1;
      for (int i = 1; i <= 47; i++) frame(8'h00, 6);
      checkOutput("grav_early_valid", bus.cmd_valid, 8'd0);
      expQ.push_back(CMD_GRAVITY);
      applyStimulus(8'h00);
      checkOutput("grav48_valid", bus.cmd_valid, 8'd1);
      checkOutput("grav48_cmd",   bus.cmd, CMD_GRAVITY);
      step(6);
      checkDrained("grav48_drained");

      // Left held for 19 ticks
      doReset();
      bus.cmd_ready = 1'b1;
      for (int t = 1; t <= 19; t++) begin
         if (t == 1) expQ.push_back(CMD_LEFT);
`ifdef TETRIS_DAS_EN
         if (t == 11 || t == 14 || t == 17) expQ.push_back(CMD_LEFT);
`endif
         frame(KEY_LEFT, 6);
      end
      frame(8'h00, 6);
      checkDrained("das_drained");

      // Priority and stall stability with level 15 gravity
      doReset();
      level = 4'd15;
      frame(KEY_SOFT, 1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("stall_valid", bus.cmd_valid, 8'd1);
         checkOutput("stall_cmd",   bus.cmd, CMD_SOFT_DROP);
         step(1);
      end
      frame(KEY_ROTATE, 3);
      frame(KEY_HARD, 3);
      checkOutput("stall_cmd_late", bus.cmd, CMD_SOFT_DROP);
      expQ.push_back(CMD_SOFT_DROP);
      expQ.push_back(CMD_HARD_DROP);
      expQ.push_back(CMD_ROTATE);
      expQ.push_back(CMD_GRAVITY);
      for (int i = 0; i < 4; i++) acceptOne("prio_accept");
      step(6);
      checkDrained("prio_drained");

      // Reset while a command is offered
      frame(KEY_ROTATE, 3);
      checkOutput("midreset_offer", bus.cmd, CMD_ROTATE);
      Reset = 1'b1;
      step(1);
      checkOutput("midreset_valid", bus.cmd_valid, 8'd0);
      checkOutput("midreset_cmd",   bus.cmd, CMD_NONE);
      Reset = 1'b0;
      step(2);

      // Pause: offered command drains, other flags and gravity freeze
      doReset();
      level = 4'd0;
      frame(KEY_ROTATE, 3);
      frame(KEY_HARD, 3);
      applyStimulus(KEY_PAUSE);
      checkOutput("pause_paused",  paused, 8'd1);
      checkOutput("pause_running", running, 8'd0);
      expQ.push_back(CMD_ROTATE);
      acceptOne("pause_drain");
      step(4);
      checkOutput("pause_flags_cleared", bus.cmd_valid, 8'd0);
      bus.cmd_ready = 1'b1;
      for (int i = 0; i < 100; i++) frame(8'h00, 2);
      applyStimulus(KEY_PAUSE);
      checkOutput("resume_paused",  paused, 8'd0);
      checkOutput("resume_running", running, 8'd1);
      step(4);
      for (int i = 0; i < 45; i++) frame(8'h00, 6);
      checkOutput("resume_grav_early", bus.cmd_valid, 8'd0);
      expQ.push_back(CMD_GRAVITY);
      applyStimulus(8'h00);
      checkOutput("resume_grav_valid", bus.cmd_valid, 8'd1);
      checkOutput("resume_grav_cmd",   bus.cmd, CMD_GRAVITY);
      step(6);
      checkDrained("pause_drained");

      // Level 15: gravity every second tick
      doReset();
      level = 4'd15;
      bus.cmd_ready = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         if (t % 2 == 0) expQ.push_back(CMD_GRAVITY);
         frame(8'h00, 6);
      end
      checkDrained("lvl15_drained");

      // Game over, then restart on Enter
      doReset();
      level = 4'd0;
      bus.cmd_ready = 1'b1;
      game_over = 1'b1;
      frame(KEY_ROTATE, 4);
      checkOutput("over_running", running, 8'd0);
      checkOutput("over_paused",  paused, 8'd0);
      checkOutput("over_valid",   bus.cmd_valid, 8'd0);
      game_over = 1'b0;
      frame(KEY_SOFT, 6);
      frame(KEY_HARD, 6);
      checkOutput("over_silent", bus.cmd_valid, 8'd0);
      expQ.push_back(CMD_RESTART);
      applyStimulus(KEY_ENTER);
      checkOutput("restart_running", running, 8'd1);
      checkOutput("restart_valid",   bus.cmd_valid, 8'd1);
      checkOutput("restart_cmd",     bus.cmd, CMD_RESTART);
      step(6);
      checkDrained("restart_drained");

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
